// File: rtl/demux16_16bit_reg.sv
// Registered 1-to-16 word distributor: valid/ready write side, per-channel valid/ack drain,
// and a registered count of occupied channels.
module demux16_16bit_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      din,
  input  logic [3:0]            sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [16*WIDTH-1:0]   out_data,
  output logic [15:0]           out_valid,
  input  logic [15:0]           out_ack,
  output logic [4:0]            occupancy
);

  logic [15:0][WIDTH-1:0] d;
  logic [15:0]            f;
  logic [15:0]            wr;
  logic [15:0]            drain;
  logic                   accept;
  logic                   wr_new;
  logic [4:0]             drain_cnt;

  // A full channel can still accept when its consumer empties it in the same cycle.
  assign in_ready = !rst && (!f[sel] || out_ack[sel]);
  assign accept   = in_valid && in_ready;
  assign wr_new   = accept && !f[sel];

  always_comb begin
    wr        = '0;
    drain     = '0;
    drain_cnt = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      wr[k]     = accept && (sel == 4'(k));
      drain[k]  = out_ack[k] && f[k] && !wr[k];
      drain_cnt = drain_cnt + 5'(drain[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d         <= '0;
      f         <= '0;
      occupancy <= '0;
    end else begin
      for (int unsigned k = 0; k < 16; k++) begin
        if (wr[k]) begin
          d[k] <= din;
          f[k] <= 1'b1;
        end else if (drain[k]) begin
          f[k] <= 1'b0;
        end
      end
      occupancy <= occupancy + 5'(wr_new) - drain_cnt;
    end
  end

  assign out_data  = d;
  assign out_valid = f;

endmodule

// File: tb/tb_demux16_16bit_reg.sv
// Bench for demux16_16bit_reg: directed scenarios plus randomized traffic against
// an array-based model of the sixteen holding slots.
module tb_demux16_16bit_reg;
  localparam int unsigned WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [WIDTH-1:0]     din = '0;
  logic [3:0]           sel = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [16*WIDTH-1:0]  out_data;
  logic [15:0]          out_valid;
  logic [15:0]          out_ack = '0;
  logic [4:0]           occupancy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] md [16];
  bit               mf [16];

  always #5 clk = ~clk;

  demux16_16bit_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ack(out_ack), .occupancy(occupancy)
  );

  function automatic int model_count();
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(mf[k]);
    return n;
  endfunction

  function automatic bit model_ready();
    return !mf[sel] || out_ack[sel];
  endfunction

  function automatic logic [15:0] exp_valid();
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = mf[k];
    return r;
  endfunction

  function automatic logic [16*WIDTH-1:0] exp_data();
    logic [16*WIDTH-1:0] r;
    for (int k = 0; k < 16; k++) r[k*WIDTH +: WIDTH] = md[k];
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      md[k] = '0;
      mf[k] = 1'b0;
    end
  endtask

  // Consumers empty their slots first, then an accepted word fills its slot.
  task automatic tick();
    bit acc;
    acc = in_valid && model_ready();
    for (int k = 0; k < 16; k++) if (out_ack[k]) mf[k] = 1'b0;
    if (acc) begin
      md[sel] = din;
      mf[sel] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ack  = '0;
  endtask

  task automatic test_reset();
    model_reset();
    in_valid = 1'b1; sel = 4'd3;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_init got %0b want 0", in_ready); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_occ_init got %0d want 0", occupancy); end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    sel = 4'd3; din = 16'h3333; in_valid = 1'b1; tick();
    sel = 4'd9; din = 16'h9999; tick();
    idle();
    checks++; if (out_valid !== 16'h0208) begin errors++; $display("FAIL reset_prefill got %h want 0208", out_valid); end
    #2; rst = 1'b1; model_reset();
    in_valid = 1'b1; sel = 4'd3; din = 16'h7777;
    #1;
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL reset_async_valid got %h want 0000", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_async_data got %h want 0", out_data); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL reset_async_occ got %0d want 0", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_async_ready got %0b want 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 16'h0000) begin
      errors++; $display("FAIL reset_held got ready=%0b valid=%h want 0/0000", in_ready, out_valid);
    end
    @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_write();
    sel = 4'd5; din = 16'hA5A5; in_valid = 1'b1;
    tick(); idle();
    checks++; if (out_valid !== 16'h0020) begin errors++; $display("FAIL single_valid got %h want 0020", out_valid); end
    checks++; if (out_data[95:80] !== 16'hA5A5) begin errors++; $display("FAIL single_data got %h want a5a5", out_data[95:80]); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL single_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_blocked();
    sel = 4'd5; din = 16'h1111; in_valid = 1'b1; out_ack = '0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL blocked_ready got %0b want 0", in_ready); end
    tick();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL blocked_ready_after got %0b want 0", in_ready); end
    idle();
    checks++; if (out_data[95:80] !== 16'hA5A5) begin errors++; $display("FAIL blocked_data got %h want a5a5", out_data[95:80]); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL blocked_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_ack_write();
    sel = 4'd5; din = 16'h1234; in_valid = 1'b1; out_ack = 16'h0020;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ackwr_ready got %0b want 1", in_ready); end
    tick(); idle();
    checks++; if (out_data[95:80] !== 16'h1234) begin errors++; $display("FAIL ackwr_data got %h want 1234", out_data[95:80]); end
    checks++; if (out_valid[5] !== 1'b1) begin errors++; $display("FAIL ackwr_valid got %0b want 1", out_valid[5]); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL ackwr_occ got %0d want 1", occupancy); end
  endtask

  task automatic test_fill_drain();
    out_ack = 16'hFFFF; tick(); idle();
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL fill_pre_occ got %0d want 0", occupancy); end
    for (int k = 0; k < 16; k++) begin
      sel = 4'(k); din = 16'(k); in_valid = 1'b1;
      tick();
    end
    idle();
    checks++; if (occupancy !== 5'd16) begin errors++; $display("FAIL fill_occ got %0d want 16", occupancy); end
    checks++; if (out_valid !== 16'hFFFF) begin errors++; $display("FAIL fill_valid got %h want ffff", out_valid); end
    checks++; if (out_data !== exp_data()) begin errors++; $display("FAIL fill_data got %h want %h", out_data, exp_data()); end
    out_ack = 16'hFFFF; tick(); idle();
    checks++; if (out_valid !== 16'h0000) begin errors++; $display("FAIL drain_valid got %h want 0000", out_valid); end
    checks++; if (occupancy !== 5'd0) begin errors++; $display("FAIL drain_occ got %0d want 0", occupancy); end
    checks++; if (out_data !== exp_data()) begin errors++; $display("FAIL drain_data_kept got %h want %h", out_data, exp_data()); end
  endtask

  task automatic test_spurious_ack();
    out_ack = 16'h8001; tick(); idle();
    checks++; if (out_valid !== 16'h0000 || occupancy !== 5'd0) begin
      errors++; $display("FAIL spurious_state got valid=%h occ=%0d want 0000/0", out_valid, occupancy);
    end
    out_ack = 16'h8001; sel = 4'd0; din = 16'hBEEF; in_valid = 1'b1;
    tick(); idle();
    checks++; if (out_valid !== 16'h0001) begin errors++; $display("FAIL spurious_wr_valid got %h want 0001", out_valid); end
    checks++; if (occupancy !== 5'd1) begin errors++; $display("FAIL spurious_wr_occ got %0d want 1", occupancy); end
    checks++; if (out_data[15:0] !== 16'hBEEF) begin errors++; $display("FAIL spurious_wr_data got %h want beef", out_data[15:0]); end
  endtask

  task automatic test_random();
    bit pending = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!pending) begin
        in_valid = ($urandom_range(0, 3) != 0);
        sel      = 4'($urandom_range(0, 15));
        din      = 16'($urandom);
      end
      out_ack = 16'($urandom) & 16'($urandom);
      #1;
      checks++; if (in_ready !== model_ready()) begin
        errors++; $display("FAIL rand_ready cyc %0d got %0b want %0b", n, in_ready, model_ready());
      end
      pending = in_valid && !model_ready();
      tick();
      checks++; if (out_valid !== exp_valid() || occupancy !== 5'(model_count())) begin
        errors++; $display("FAIL rand_state cyc %0d got valid=%h occ=%0d want %h/%0d",
                           n, out_valid, occupancy, exp_valid(), model_count());
      end
      checks++; if (out_data !== exp_data()) begin
        errors++; $display("FAIL rand_data cyc %0d got %h want %h", n, out_data, exp_data());
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_blocked();
    test_ack_write();
    test_fill_drain();
    test_spurious_ack();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux16_16bit_reg.md
# demux16_16bit_reg

Registered 1-to-16 distributor for 16-bit words; the write-side counterpart to the 16:1 result-select path in the ALU. A producer presents a word with a 4-bit destination select under a valid/ready handshake. The word is captured into one of 16 per-channel holding registers, and each channel is drained independently by its consumer through a valid/ack pair. A registered occupancy count reports how many channels currently hold data.

## Interface
- WIDTH, 16, data word width; the channel count is fixed at 16 by the 4-bit select.

- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- din  input  WIDTH  write data
- sel  input  4  destination channel, 0..15
- in_valid  input  1  producer presents din/sel this cycle
- in_ready  output  1  block can accept a word for channel sel this cycle
- out_data  output  16*WIDTH  channel k data at [WIDTH*k+WIDTH-1 : WIDTH*k]
- out_valid  output  16  bit k: channel k holds an unconsumed word
- out_ack  input  16  bit k: consumer k takes channel k's word this cycle
- occupancy  output  5  number of full channels, 0..16

## Operation
- State per channel k:
  - data register d[k] (WIDTH bits)
  - full flag f[k]
  - out_data slice k = d[k]
  - out_valid[k] = f[k]
- Ready logic, combinational: in_ready = !rst & (!f[sel] | out_ack[sel]).
- Write: when in_valid & in_ready, at the clock edge d[sel] <= din and f[sel] <= 1.
- Drain: when out_ack[k] & f[k] and no write to channel k in the same cycle, f[k] <= 0.
  - d[k] is retained, not cleared.
- Ack on an empty channel (out_ack[k] & !f[k]) is ignored and changes no state.
- Same-channel simultaneous ack and write:
  - the old word is consumed and the new word is captured
  - f[k] stays 1; occupancy is unchanged
- Multiple channels may be acked in the same cycle; each ack behaves independently.
- A write to channel j and acks on other channels may occur in the same cycle.
- Blocked write: in_valid with f[sel]=1 and no out_ack[sel] → in_ready=0 and nothing changes. The producer must hold din/sel stable until accepted.
- Occupancy update, registered, per cycle:
  - +1 if a write lands on an empty channel
  - minus the number of channels that go full→empty
  - equals popcount(f) at all times; never exceeds 16 and never underflows
- sel is fully decoded; all 16 values are legal. There is no default or illegal case.
- Asynchronous reset, immediately on rst rising, independent of clk:
  - every d[k] = 0, every f[k] = 0, occupancy = 0
  - out_data = 0, out_valid = 16'h0000
  - in_ready forced to 0 while rst is high
- Reset mid-operation discards all stored words, with no partial write.
- First accept is possible on the first clk edge after rst deasserts.

## Timing
- Write latency 1 cycle: a word accepted at edge N appears on out_data/out_valid immediately after edge N.
- Drain latency 1 cycle: an ack sampled at edge N drops out_valid[k] after edge N.
- occupancy updates on the same edge as the f[] change it reflects.
- in_ready is combinational from sel, out_ack and f; there are no registered stalls.
- Throughput is one write per cycle when target channels are free or are being acked.
- No combinational path from din to any output.

## Test plan
- Reset: assert rst mid-cycle with channels 3 and 9 full → out_valid=0, out_data=0 and occupancy=0 immediately; in_ready=0 until rst falls.
- Single write: sel=5, din=16'hA5A5, in_valid=1 for one cycle → next cycle:
  - out_valid=16'h0020
  - out_data[95:80]=16'hA5A5
  - occupancy=1
- Blocked write: channel 5 full, no ack, sel=5, din=16'h1111 → in_ready=0 for the whole cycle; out_data[95:80] remains 16'hA5A5 and occupancy stays 1.
- Same-cycle ack+write: channel 5 full, out_ack[5]=1, sel=5, din=16'h1234 → in_ready=1; next cycle out_data[95:80]=16'h1234, out_valid[5]=1, occupancy=1.
- Fill and drain:
  - write channels 0..15 with din=k on consecutive cycles → occupancy=16, out_valid=16'hFFFF
  - then out_ack=16'hFFFF for one cycle → out_valid=0, occupancy=0
- Spurious ack: all channels empty, out_ack=16'h8001 → no state change and occupancy=0; a write to ch 0 in the same cycle still sets f[0] and gives occupancy=1.
